logic_unit_pipe: RTL
====================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, pipelined bitwise logic unit: the WIDTH-bit, op-selectable successor of the
//  single-bit gate set (NOT/AND/OR/NAND/NOR/XOR/XNOR). It sits between a producer and a consumer
//  on valid/ready streams, registers every result, and reports zero/parity flags and a completed-op
//  count. It is used as the logic leg of datapath exercises and as a handshake/pipeline reference.
// PARAMETERS
//  WIDTH  default 8   operand/result width in bits (>=1)
//  CNT_W  default 16  width of op_count (>=1)
// PORTS
//  clk        in   1      rising-edge clock; single clock domain
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      producer presents a, b, op this cycle
//  in_ready   out  1      unit can accept; transfer when in_valid & in_ready
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (ignored by ops 000 and 111)
//  op         in   3      operation select, see BEHAVIOUR
//  out_valid  out  1      y/zero/parity hold a valid result
//  out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
//  y          out  WIDTH  result
//  zero       out  1      1 when y == 0
//  parity     out  1      XOR-reduction of y
//  op_count   out  CNT_W  number of results delivered (output transfers) since reset
// BEHAVIOUR
//  - Op encoding (bitwise across WIDTH): 000 ~a, 001 a&b, 010 a|b, 011 ~(a&b), 100 ~(a|b),
//    101 a^b, 110 ~(a^b), 111 a (pass).
//  - Two register stages. S1 captures {a,b,op} on an input transfer. S2 captures the computed
//    y/zero/parity from S1. Latency: result is valid 2 cycles after the input transfer edge when
//    not stalled. Throughput: 1 op/cycle with out_ready held high.
//  - Stage advance: S2 loads when S1 valid and (S2 empty or out_ready). S1 loads when
//    in_valid and in_ready. in_ready = ~s1_valid | s2_can_load (combinational from out_ready;
//    no combinational path from in_valid to in_ready).
//  - Backpressure: with out_ready=0 and both stages full, in_ready=0; y, zero, parity, out_valid
//    hold stable until accepted. Results never dropped, duplicated or reordered.
//  - Simultaneous events: output transfer and S1->S2 move in the same cycle are legal; input
//    transfer into S1 in the same cycle S1 drains is legal (full-rate streaming).
//  - out_valid without a prior transfer never occurs; a, b, op are sampled only on a transfer.
//  - op_count increments by 1 on each output transfer; wraps 2^CNT_W-1 -> 0 silently.
//  - Reset (asynchronous, any time, including mid-stream): out_valid=0, internal S1 valid=0,
//    y=0, zero=1, parity=0, op_count=0; in-flight operations are discarded. in_ready=1 while
//    rst=0 and the pipeline is empty, including the first cycle after reset release.
//  - WIDTH=1 must reproduce the single-bit gate truth tables exactly.
// TESTING (WIDTH=8, CNT_W=4 unless stated)
//  1 Truth table: for op 0..7 with a=8'hA5, b=8'h3C, out_ready=1 -> y = 5A,24,BD,DB,42,99,66,A5
//    two cycles after each transfer; zero=0; parity matches $countones(y)[0].
//  2 Flags: op=001 a=8'hF0 b=8'h0F -> y=00, zero=1, parity=0; op=111 a=8'h01 -> parity=1.
//  3 Backpressure: stream 4 ops with out_ready=0 -> in_ready drops after 2 accepts; y holds
//    first result; raise out_ready -> all 4 results emerge in order, none lost.
//  4 Full rate: in_valid=out_ready=1 for 20 cycles -> 20 results, one per cycle after 2-cycle
//    fill; op_count wraps 15->0 at the 16th transfer and reads 4 at the end.
//  5 Reset mid-stream: assert rst asynchronously (between edges) with both stages full ->
//    out_valid=0, op_count=0, y=0, zero=1 immediately; no stale result appears after release.
//  6 WIDTH=1 build: exhaustive a,b in {0,1} x op 0..6 -> matches NOT/AND/OR/NAND/NOR/XOR/XNOR.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//
// Two-stage pipelined bitwise logic unit between valid/ready streams.
// S1 registers {a, b, op} on an input transfer. S2 registers the computed
// result together with its zero and parity flags. op_count counts delivered
// results and wraps silently.
//
// Parameters
//   WIDTH   operand/result width (>= 1)
//   CNT_W   width of op_count (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   producer presents a, b, op
//   in_ready   unit can accept (transfer = in_valid & in_ready)
//   a, b       operands (b unused by NOT and PASS)
//   op         000 ~a, 001 a&b, 010 a|b, 011 ~(a&b), 100 ~(a|b),
//              101 a^b, 110 ~(a^b), 111 a
//   out_valid  y/zero/parity hold a result
//   out_ready  consumer accepts (transfer = out_valid & out_ready)
//   y          result
//   zero       1 when y == 0
//   parity     XOR-reduction of y
//   op_count   output transfers since reset, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XOR  = 3'b101,
        OP_XNOR = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    // Stage 1: captured operands
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;

    // Combinational result of the S1 contents
    logic [WIDTH-1:0] s1_y;

    // Handshake / advance controls
    logic s2_can_load;
    logic s2_load;
    logic s1_load;
    logic out_fire;

    // S2 is free when empty or when its result leaves this cycle, so a full
    // pipeline keeps streaming at one op per cycle. in_ready depends only on
    // state and out_ready, never on in_valid.
    assign s2_can_load = ~out_valid | out_ready;
    assign s2_load     = s1_valid & s2_can_load;
    assign in_ready    = ~s1_valid | s2_can_load;
    assign s1_load     = in_valid & in_ready;
    assign out_fire    = out_valid & out_ready;

    // NOTE: every variable assigned in an always_comb gets a default first so
    // no path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        s1_y = s1_a;
        case (s1_op)
            OP_NOT:  s1_y = ~s1_a;
            OP_AND:  s1_y = s1_a & s1_b;
            OP_OR:   s1_y = s1_a | s1_b;
            OP_NAND: s1_y = ~(s1_a & s1_b);
            OP_NOR:  s1_y = ~(s1_a | s1_b);
            OP_XOR:  s1_y = s1_a ^ s1_b;
            OP_XNOR: s1_y = ~(s1_a ^ s1_b);
            OP_PASS: s1_y = s1_a;
            default: s1_y = s1_a;
        endcase
    end

    // Stage 1 valid flag. A new load wins over a drain in the same cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // NOTE: operand registers carry no reset; s1_valid qualifies them, so
    // their power-up contents are never observed.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_a  <= a;
            s1_b  <= b;
            s1_op <= op_e'(op);
        end
    end

    // Stage 2: result and flags; reset to the values of an all-zero result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b1;
            parity    <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            y         <= s1_y;
            zero      <= (s1_y == '0);
            parity    <= ^s1_y;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Delivered-result counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (out_fire) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule
